game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Top-level game sequencer for the Flappy Bird datapath. Conditions the raw flap button and runs the
//  IDLE/PLAY/DEAD(/PAUSE) state machine. Drives the 2-bit state bus consumed by Display,
//  Bird_Ctrl and Pipe_Generator. Tracks the session best score.
//  Sits between board I/O and Display; runs on the main board clock.
// PARAMETERS
//  DB_CYCLES    500_000      cycles a synchronised button level must stay stable before acceptance (5 ms @ 100 MHz)
//  HOLD_CYCLES  100_000_000  minimum DEAD dwell, in cycles, before a press is honoured (1 s @ 100 MHz)
//  SCORE_W      8            score / best-score width
// PORTS
//  clk         in   1        main board clock
//  rst         in   1        synchronous, active-high reset
//  btn_raw     in   1        raw flap button, asynchronous, bouncy
//  pause_sw    in   1        pause switch level, asynchronous; used only with GAME_PAUSE_EN
//  isDead      in   1        collision flag from Bird_Ctrl, level
//  score       in   SCORE_W  live score from Pipe_Generator
//  state       out  2        00 IDLE, 01 PLAY, 10 DEAD, 11 PAUSE
//  up_button   out  1        debounced button level, to Bird_Ctrl
//  btn_press   out  1        1-cycle pulse on debounced rising edge
//  best_score  out  SCORE_W  highest final score since reset
//  new_best    out  1        high while in DEAD if the last game set a new best
// BEHAVIOUR
//  Reset: all outputs and internal registers are 0. This gives state=IDLE and a 0 hold timer.
//    Any operation in progress is abandoned. The debounce counter clears, so a press held through reset
//    needs a full DB_CYCLES after rst falls.
//  Input sync: btn_raw and pause_sw each pass through a 2-flop synchroniser.
//  Debounce:
//    - The counter resets whenever the synchronised level differs from up_button.
//    - When it reaches DB_CYCLES-1, up_button takes the new level.
//    - btn_press pulses on the same cycle that up_button rises 0->1.
//    - Latency from a clean raw edge to btn_press is DB_CYCLES+2 cycles.
//  Button-to-FSM gating: the FSM acts only on btn_press. In PLAY the FSM ignores btn_press; the flap
//    is carried by up_button.
//  FSM, one transition per clk, registered:
//    IDLE -> PLAY   on btn_press.
//    PLAY -> DEAD   on isDead=1. In the same cycle, score is compared with best_score.
//                   - If score > best_score, best_score<=score and new_best<=1.
//                   - Otherwise new_best<=0.
//                   - An equal score is not a new best.
//    DEAD:          the hold timer counts from 0 and saturates at HOLD_CYCLES-1.
//                   - btn_press before saturation is discarded.
//                   - After saturation, btn_press -> IDLE, clears new_best and the timer.
//                   - Entering IDLE lets Bird_Ctrl and Pipe_Generator reinitialise.
//  isDead is ignored outside PLAY. A stale isDead in IDLE does not cause a transition.
//  best_score changes only on the PLAY->DEAD edge. It never decreases; it is cleared only by rst.
//  Widths: the hold and debounce counters are $clog2(param) bits wide. No wrap, saturating only.
// CONFIGURATION
//  GAME_PAUSE_EN defined:
//    - PLAY and synced pause_sw=1 -> PAUSE (11).
//    - PAUSE and pause_sw=0 -> PLAY.
//    - isDead and btn_press are ignored in PAUSE.
//    - If pause_sw=1 and isDead=1 in the same PLAY cycle, DEAD wins.
//  GAME_PAUSE_EN undefined: pause_sw is unused and the PAUSE state is absent. state never equals 11.
// STRUCTURE
//  Shared header game_defs.vh: state encodings ST_IDLE/ST_PLAY/ST_DEAD/ST_PAUSE, used by Display,
//    Bird_Ctrl, Pipe_Generator and this block.
//  Sub-module btn_debounce: synchroniser, counter, level and press outputs, parameter DB_CYCLES.
//    It is instantiated once here.
//  FSM, hold timer and best-score logic are flat in this module.
// TESTING  (bench uses DB_CYCLES=4, HOLD_CYCLES=8)
//  1. rst=1 for 3 cycles with btn_raw=1 -> state=00, best_score=0, new_best=0.
//     btn_press first pulses 6 cycles after rst falls.
//  2. btn_raw toggles every 2 cycles for 20 cycles, then holds 1 -> exactly one btn_press, 6 cycles after the final edge.
//     Then state 00->01.
//  3. In PLAY, score=37, assert isDead -> next cycle state=10, best_score=37, new_best=1.
//     Replay with score=37 -> new_best=0, best_score stays 37.
//  4. In DEAD, press at dwell cycle 3 -> ignored, state stays 10.
//     Press after dwell cycle 8 -> state=00, new_best=0.
//  5. GAME_PAUSE_EN: in PLAY raise pause_sw -> state=11 after sync (3 cycles).
//     isDead pulse during PAUSE is ignored. Drop pause_sw -> state=01.
//     pause_sw and isDead rising together -> state=10.
//  6. rst asserted mid-DEAD with best_score=37 -> next cycle state=00, best_score=0, timer=0.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// Shared definitions for the game sequencer: state bus encoding and counter sizing.
package game_flow_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PLAY  = 2'b01,
        ST_DEAD  = 2'b10,
        ST_PAUSE = 2'b11
    } game_state_t;

    // Width of a saturating counter that must reach n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/game_flow_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser, stability counter, debounced level and rising-edge press pulse.
module btn_debounce
    import game_flow_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES = 500_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);

    localparam int unsigned      CNT_W   = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_press <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_press <= 1'b0;
            // Count only while the synced level disagrees with the accepted level.
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_cnt   <= '0;
                r_level <= r_sync2;
                r_press <= r_sync2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_press = r_press;

endmodule

// File: rtl/game_flow_ctrl.sv
// Flappy Bird game sequencer: IDLE/PLAY/DEAD FSM, DEAD hold timer and session best score.
// Optional PAUSE state is built only when GAME_PAUSE_EN is defined.
module game_flow_ctrl
    import game_flow_ctrl_pkg::*;
#(
    parameter int unsigned DB_CYCLES   = 500_000,
    parameter int unsigned HOLD_CYCLES = 100_000_000,
    parameter int unsigned SCORE_W     = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               btn_raw,
    input  logic               pause_sw,
    input  logic               isDead,
    input  logic [SCORE_W-1:0] score,
    output logic [1:0]         state,
    output logic               up_button,
    output logic               btn_press,
    output logic [SCORE_W-1:0] best_score,
    output logic               new_best
);

    localparam int unsigned       HOLD_W   = cnt_width(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_CYCLES - 1);

    game_state_t        r_state;
    game_state_t        w_next;
    logic [HOLD_W-1:0]  r_hold;
    logic [SCORE_W-1:0] r_best;
    logic               r_new_best;
    logic               w_up;
    logic               w_press;
    logic               w_hold_done;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_raw   (btn_raw),
        .o_level (w_up),
        .o_press (w_press)
    );

`ifdef GAME_PAUSE_EN
    logic r_psync1;
    logic r_psync2;
    logic w_pause;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_psync1 <= 1'b0;
            r_psync2 <= 1'b0;
        end else begin
            r_psync1 <= pause_sw;
            r_psync2 <= r_psync1;
        end
    end

    assign w_pause = r_psync2;
`else
    logic w_unused_pause;
    assign w_unused_pause = pause_sw;
`endif

    assign w_hold_done = (r_hold == HOLD_MAX);

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_press) w_next = ST_PLAY;
            // Death takes priority over a simultaneous pause request.
            ST_PLAY: begin
                if (isDead) w_next = ST_DEAD;
`ifdef GAME_PAUSE_EN
                else if (w_pause) w_next = ST_PAUSE;
`endif
            end
            ST_DEAD: if (w_press && w_hold_done) w_next = ST_IDLE;
`ifdef GAME_PAUSE_EN
            ST_PAUSE: if (!w_pause) w_next = ST_PLAY;
`endif
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_hold     <= '0;
            r_best     <= '0;
            r_new_best <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_state == ST_PLAY && w_next == ST_DEAD) begin
                if (score > r_best) begin
                    r_best     <= score;
                    r_new_best <= 1'b1;
                end else begin
                    r_new_best <= 1'b0;
                end
            end else if (r_state == ST_DEAD && w_next == ST_IDLE) begin
                r_new_best <= 1'b0;
            end

            // Timer runs only while staying in DEAD, so every DEAD entry starts at zero.
            if (r_state == ST_DEAD && w_next == ST_DEAD) begin
                if (!w_hold_done) r_hold <= r_hold + 1'b1;
            end else begin
                r_hold <= '0;
            end
        end
    end

    assign state      = r_state;
    assign up_button  = w_up;
    assign btn_press  = w_press;
    assign best_score = r_best;
    assign new_best   = r_new_best;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Self-checking bench for game_flow_ctrl: directed scenarios plus randomized play against a reference model.
module tb_game_flow_ctrl;

    localparam int DB   = 4;
    localparam int HOLD = 8;
`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_ON = 1'b1;
`else
    localparam bit PAUSE_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_raw = 1'b0;
    logic       pause_sw = 1'b0;
    logic       isDead = 1'b0;
    logic [7:0] score = '0;
    logic [1:0] state;
    logic       up_button;
    logic       btn_press;
    logic [7:0] best_score;
    logic       new_best;

    int errors = 0;
    int checks = 0;

    // Reference model: state as plain ints, button filter as a sliding window over raw history.
    int m_state, m_best, m_nb, m_dwell;
    bit m_level, m_press;
    bit rhist[$];
    bit phist[$];

    always #5 clk = ~clk;

    game_flow_ctrl #(
        .DB_CYCLES   (DB),
        .HOLD_CYCLES (HOLD),
        .SCORE_W     (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .pause_sw   (pause_sw),
        .isDead     (isDead),
        .score      (score),
        .state      (state),
        .up_button  (up_button),
        .btn_press  (btn_press),
        .best_score (best_score),
        .new_best   (new_best)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int nxt;
        bit all_opp;
        bit psync;
        if (rst) begin
            m_state = 0; m_best = 0; m_nb = 0; m_dwell = 0;
            m_level = 1'b0; m_press = 1'b0;
            rhist.delete(); phist.delete();
            for (int i = 0; i < DB + 2; i++) begin
                rhist.push_back(1'b0);
                phist.push_back(1'b0);
            end
        end else begin
            nxt   = m_state;
            psync = phist[1];
            case (m_state)
                0: if (m_press) nxt = 1;
                1: begin
                    if (isDead) begin
                        nxt = 2;
                        m_dwell = 0;
                        if (int'(score) > m_best) begin m_best = int'(score); m_nb = 1; end
                        else m_nb = 0;
                    end else if (PAUSE_ON && psync) begin
                        nxt = 3;
                    end
                end
                2: begin
                    if (m_press && m_dwell >= HOLD - 1) begin nxt = 0; m_nb = 0; end
                    else if (m_dwell < HOLD - 1) m_dwell++;
                end
                default: if (!psync) nxt = 1;
            endcase
            m_state = nxt;
            // The level flips once the synced input has shown the opposite value for DB consecutive samples.
            all_opp = 1'b1;
            for (int i = 1; i <= DB; i++) if (rhist[i] == m_level) all_opp = 1'b0;
            m_press = all_opp && !m_level;
            if (all_opp) m_level = !m_level;
            rhist.push_front(btn_raw); void'(rhist.pop_back());
            phist.push_front(pause_sw); void'(phist.pop_back());
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_eq("state", 32'(state), 32'(m_state));
        check_eq("up_button", 32'(up_button), 32'(m_level));
        check_eq("btn_press", 32'(btn_press), 32'(m_press));
        check_eq("best_score", 32'(best_score), 32'(m_best));
        check_eq("new_best", 32'(new_best), 32'(m_nb));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_clean();
        btn_raw = 1'b1; ticks(8);
        btn_raw = 1'b0; ticks(8);
    endtask

    task automatic die(input int s);
        score = 8'(s); isDead = 1'b1; tick(); isDead = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int np;
        int remaining;
        int len;

        // Reset with the button already held: first press needs a full filter period after release.
        rst = 1'b1; btn_raw = 1'b1;
        ticks(3);
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_best", 32'(best_score), 32'd0);
        check_eq("rst_new_best", 32'(new_best), 32'd0);
        rst = 1'b0; lat = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (btn_press === 1'b1 && lat == 0) lat = i;
        end
        check_eq("rst_press_lat", 32'(lat), 32'd6);
        check_eq("t1_play", 32'(state), 32'd1);
        btn_raw = 1'b0; ticks(8);

        // First death with a fresh best.
        die(37);
        check_eq("t3_dead", 32'(state), 32'd2);
        check_eq("t3_best", 32'(best_score), 32'd37);
        check_eq("t3_new_best", 32'(new_best), 32'd1);

        // Early press during the DEAD dwell is discarded.
        btn_raw = 1'b1; ticks(8);
        check_eq("t4_early_ignored", 32'(state), 32'd2);
        btn_raw = 1'b0; ticks(8);
        press_clean();
        check_eq("t4_idle", 32'(state), 32'd0);
        check_eq("t4_new_best_clr", 32'(new_best), 32'd0);

        // Bouncy press: only the final stable edge is accepted.
        np = 0;
        for (int i = 0; i < 20; i++) begin
            btn_raw = ((i / 2) % 2) == 0;
            tick();
            if (btn_press === 1'b1) np++;
        end
        btn_raw = 1'b1; lat = 0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (btn_press === 1'b1) begin np++; if (lat == 0) lat = i; end
        end
        check_eq("t2_press_count", 32'(np), 32'd1);
        check_eq("t2_press_lat", 32'(lat), 32'd6);
        check_eq("t2_play", 32'(state), 32'd1);
        btn_raw = 1'b0; ticks(8);

        // Equal score is not a new best.
        die(37);
        check_eq("t3b_new_best", 32'(new_best), 32'd0);
        check_eq("t3b_best", 32'(best_score), 32'd37);
        ticks(10);
        press_clean();
        check_eq("t3b_idle", 32'(state), 32'd0);

`ifdef GAME_PAUSE_EN
        press_clean();
        pause_sw = 1'b1; ticks(3);
        check_eq("t5_pause", 32'(state), 32'd3);
        isDead = 1'b1; tick(); isDead = 1'b0; ticks(2);
        check_eq("t5_pause_dead_ign", 32'(state), 32'd3);
        pause_sw = 1'b0; ticks(3);
        check_eq("t5_resume", 32'(state), 32'd1);
        pause_sw = 1'b1; die(20);
        check_eq("t5_dead_wins", 32'(state), 32'd2);
        pause_sw = 1'b0; ticks(10);
        press_clean();
`endif

        // Randomized play.
        remaining = 3000;
        while (remaining > 0) begin
            len = $urandom_range(1, 12);
            btn_raw = 1'($urandom % 2);
            if ($urandom % 8 == 0) pause_sw = ~pause_sw;
            for (int i = 0; i < len; i++) begin
                isDead = ($urandom % 16) == 0;
                score  = ($urandom % 4 == 0) ? 8'(m_best) : 8'($urandom_range(0, 255));
                tick();
            end
            remaining -= len;
        end
        isDead = 1'b0; pause_sw = 1'b0; btn_raw = 1'b0;

        // Reset in the middle of DEAD clears everything.
        rst = 1'b1; ticks(2); rst = 1'b0;
        press_clean();
        die(37);
        ticks(3);
        check_eq("t6_pre_best", 32'(best_score), 32'd37);
        rst = 1'b1; tick();
        check_eq("t6_state", 32'(state), 32'd0);
        check_eq("t6_best", 32'(best_score), 32'd0);
        check_eq("t6_new_best", 32'(new_best), 32'd0);
        rst = 1'b0; ticks(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
